// File: rtl/layer_tdm.sv
// Time-multiplexed fully-connected layer: `lanes` shared MACs sweep neuron groups.
// Define LAYER_TDM_SAT_COUNT_EN to build the per-run saturation counter on sat_count.
module layer_tdm #(
    parameter int bits            = 16,
    parameter int fractional_bits = 8,
    parameter int in_size         = 16,
    parameter int out_size        = 8,
    parameter int lanes           = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic signed [bits-1:0] in      [0:in_size-1],
    input  logic signed [bits-1:0] weights [0:in_size*out_size-1],
    input  logic signed [bits-1:0] biases  [0:out_size-1],
    input  logic [1:0]             act_mode,
    output logic signed [bits-1:0] out     [0:out_size-1],
    output logic                   ready,
    output logic                   busy,
    output logic [15:0]            sat_count
);
    localparam int GROUPS = out_size / lanes;
    localparam int ACC_W  = 2*bits + $clog2(in_size) + 1;
    localparam int KW     = (in_size > 1) ? $clog2(in_size) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int NW     = (out_size > 1) ? $clog2(out_size) : 1;
    localparam int WW     = (in_size*out_size > 1) ? $clog2(in_size*out_size) : 1;

    localparam logic signed [ACC_W-1:0] RND  = (ACC_W'(1) << fractional_bits) >> 1;
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (bits-1)) - 1;
    localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) << (bits-1));

    generate
        if (out_size % lanes != 0) begin : g_bad_lanes
            $error("layer_tdm: out_size must be a multiple of lanes");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [GW-1:0]          grp_q, grp_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic [1:0]             mode_q, mode_d;
    logic signed [bits-1:0] in_q  [0:in_size-1];
    logic signed [bits-1:0] in_d  [0:in_size-1];
    logic signed [bits-1:0] w_q   [0:in_size*out_size-1];
    logic signed [bits-1:0] w_d   [0:in_size*out_size-1];
    logic signed [bits-1:0] b_q   [0:out_size-1];
    logic signed [bits-1:0] b_d   [0:out_size-1];
    logic signed [bits-1:0] out_q [0:out_size-1];
    logic signed [bits-1:0] out_d [0:out_size-1];
    logic signed [ACC_W-1:0] acc_q [0:lanes-1];
    logic signed [ACC_W-1:0] acc_d [0:lanes-1];

    logic signed [2*bits-1:0] mul      [0:lanes-1];
    logic signed [ACC_W-1:0]  rnd      [0:lanes-1];
    logic signed [bits-1:0]   clip     [0:lanes-1];
    logic signed [bits-1:0]   lane_res [0:lanes-1];

    function automatic logic signed [ACC_W-1:0] bias_ext(
        input logic signed [bits-1:0] b
    );
        return ACC_W'(b) <<< fractional_bits;
    endfunction

    function automatic logic signed [bits-1:0] activate(
        input logic signed [bits-1:0] x,
        input logic [1:0]             mode
    );
        logic signed [bits-1:0] y;
        unique case (mode)
            2'b00:   y = x[bits-1] ? '0 : x;
            2'b10:   y = x[bits-1] ? (x >>> 3) : x;
            default: y = x;
        endcase
        return y;
    endfunction

`ifdef LAYER_TDM_SAT_COUNT_EN
    logic        lane_sat [0:lanes-1];
    logic [15:0] sat_q, sat_d;
`endif

    // Per-lane datapath: product for the current k, and the rounded/clipped result.
    always_comb begin
        for (int j = 0; j < lanes; j++) begin
            mul[j] = in_q[k_q]
                   * w_q[WW'((int'(grp_q) * lanes + j) * in_size + int'(k_q))];
            rnd[j] = (acc_q[j] + RND) >>> fractional_bits;
            if (rnd[j] > MAXV) begin
                clip[j] = MAXV[bits-1:0];
            end else if (rnd[j] < MINV) begin
                clip[j] = MINV[bits-1:0];
            end else begin
                clip[j] = rnd[j][bits-1:0];
            end
            lane_res[j] = activate(clip[j], mode_q);
`ifdef LAYER_TDM_SAT_COUNT_EN
            lane_sat[j] = (rnd[j] > MAXV) || (rnd[j] < MINV);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        grp_d   = grp_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        mode_d  = mode_q;
        in_d    = in_q;
        w_d     = w_q;
        b_d     = b_q;
        out_d   = out_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_d    = in;
                    w_d     = weights;
                    b_d     = biases;
                    mode_d  = act_mode;
                    k_d     = '0;
                    grp_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    state_d = MAC;
                    for (int j = 0; j < lanes; j++) begin
                        acc_d[j] = bias_ext(biases[j]);
                    end
                end
            end
            MAC: begin
                for (int j = 0; j < lanes; j++) begin
                    acc_d[j] = acc_q[j] + ACC_W'(mul[j]);
                end
                k_d = k_q + 1'b1;
                if (k_q == KW'(in_size - 1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                for (int j = 0; j < lanes; j++) begin
                    out_d[NW'(int'(grp_q) * lanes + j)] = lane_res[j];
                end
                if (grp_q == GW'(GROUPS - 1)) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    grp_d   = grp_q + 1'b1;
                    k_d     = '0;
                    state_d = MAC;
                    for (int j = 0; j < lanes; j++) begin
                        acc_d[j] = bias_ext(b_q[NW'((int'(grp_q) + 1) * lanes + j)]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            grp_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            mode_q  <= '0;
            in_q    <= '{default: '0};
            w_q     <= '{default: '0};
            b_q     <= '{default: '0};
            out_q   <= '{default: '0};
            acc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            grp_q   <= grp_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            mode_q  <= mode_d;
            in_q    <= in_d;
            w_q     <= w_d;
            b_q     <= b_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
        end
    end

`ifdef LAYER_TDM_SAT_COUNT_EN
    // Counts clipped words of the current run; sticks at all-ones.
    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && start) begin
            sat_d = '0;
        end else if (state_q == WRITE) begin
            for (int j = 0; j < lanes; j++) begin
                if (lane_sat[j] && sat_d != 16'hFFFF) begin
                    sat_d = sat_d + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = '0;
`endif

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_layer_tdm.sv
// Directed + randomized bench for layer_tdm against an arithmetic reference.
module tb_layer_tdm;
    localparam int BITS  = 16;
    localparam int FRAC  = 8;
    localparam int IN    = 16;
    localparam int OUT   = 8;
    localparam int LANES = 2;
    localparam int LAT   = (OUT / LANES) * (IN + 1);

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic signed [BITS-1:0] in_v  [0:IN-1];
    logic signed [BITS-1:0] w_v   [0:IN*OUT-1];
    logic signed [BITS-1:0] b_v   [0:OUT-1];
    logic [1:0]             mode;
    logic signed [BITS-1:0] out_v [0:OUT-1];
    logic                   ready;
    logic                   busy;
    logic [15:0]            sat_count;

    int errors = 0;
    int checks = 0;
    int exp_out [0:OUT-1];
    int exp_sat;
    int cyc = 0;
    int busy_total = 0;
    int acc_cyc;
    int busy_base;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (busy) busy_total <= busy_total + 1;

    layer_tdm #(
        .bits(BITS), .fractional_bits(FRAC), .in_size(IN),
        .out_size(OUT), .lanes(LANES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in(in_v), .weights(w_v), .biases(b_v), .act_mode(mode),
        .out(out_v), .ready(ready), .busy(busy), .sat_count(sat_count)
    );

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic logic signed [BITS-1:0] rnd16(input int lim);
        int v;
        v = int'($urandom_range(2 * lim - 1, 0)) - lim;
        return 16'(v);
    endfunction

    task automatic fill_const(input int iv, input int wv, input int bv);
        for (int k = 0; k < IN; k++) in_v[k] = 16'(iv);
        for (int i = 0; i < IN * OUT; i++) w_v[i] = 16'(wv);
        for (int n = 0; n < OUT; n++) b_v[n] = 16'(bv);
    endtask

    task automatic fill_rand(input int lim);
        for (int k = 0; k < IN; k++) in_v[k] = rnd16(lim);
        for (int i = 0; i < IN * OUT; i++) w_v[i] = rnd16(lim);
        for (int n = 0; n < OUT; n++) b_v[n] = rnd16(32768);
        mode = 2'($urandom_range(3, 0));
    endtask

    // Real-number layer: exact dot product, round half up, clamp, activation.
    task automatic predict();
        longint acc;
        longint r;
        int x;
        exp_sat = 0;
        for (int n = 0; n < OUT; n++) begin
            acc = longint'(b_v[n]) * 256;
            for (int k = 0; k < IN; k++)
                acc += longint'(in_v[k]) * longint'(w_v[n * IN + k]);
            r = acc + 128;
            r = (r >= 0) ? r / 256 : -((-r + 255) / 256);
            if (r > 32767) begin
                x = 32767; exp_sat++;
            end else if (r < -32768) begin
                x = -32768; exp_sat++;
            end else begin
                x = int'(r);
            end
            if (mode == 2'b00 && x < 0) x = 0;
            if (mode == 2'b10 && x < 0) x = -((-x + 7) / 8);
            exp_out[n] = x;
        end
`ifndef LAYER_TDM_SAT_COUNT_EN
        exp_sat = 0;
`endif
    endtask

    task automatic mark();
        acc_cyc = cyc;
        busy_base = busy_total;
    endtask

    task automatic accept(input string tag);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        mark();
        check($sformatf("%s busy@ack", tag), busy, 1);
        check($sformatf("%s ready@ack", tag), ready, 0);
        check($sformatf("%s sat@ack", tag), sat_count, 0);
    endtask

    task automatic finish_run(input string tag);
        while (!ready && (cyc - acc_cyc) < 4 * LAT) begin
            @(posedge clock); #1;
        end
        check($sformatf("%s latency", tag), cyc - acc_cyc, LAT);
        check($sformatf("%s busy cycles", tag), busy_total - busy_base, LAT);
        check($sformatf("%s busy end", tag), busy, 0);
        for (int n = 0; n < OUT; n++)
            check($sformatf("%s out[%0d]", tag, n), out_v[n], exp_out[n]);
        check($sformatf("%s sat_count", tag), sat_count, exp_sat);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        mode    = 2'b00;
        fill_const(0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("reset ready", ready, 0);
        check("reset busy", busy, 0);
        check("reset sat", sat_count, 0);
        check("reset out0", out_v[0], 0);
        check("reset out7", out_v[7], 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        fill_const(16'h0100, 16'h0100, 0);
        mode = 2'b00;
        predict();
        accept("ones");
        finish_run("ones");
        check("ones const", out_v[4], 16'h1000);

        fill_const(16'h0100, 16'hFF00, 0);
        mode = 2'b00;
        predict(); accept("neg relu"); finish_run("neg relu");
        check("neg relu const", out_v[3], 0);
        mode = 2'b10;
        predict(); accept("neg leaky"); finish_run("neg leaky");
        check("neg leaky const", out_v[3], -512);
        mode = 2'b01;
        predict(); accept("neg lin"); finish_run("neg lin");
        check("neg lin const", out_v[3], -4096);

        fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
        mode = 2'b00;
        predict(); accept("sat"); finish_run("sat");
        check("sat const", out_v[6], 32767);
`ifdef LAYER_TDM_SAT_COUNT_EN
        check("sat count const", sat_count, 8);
`else
        check("sat count const", sat_count, 0);
`endif

        fill_rand(1024);
        for (int i = 0; i < IN * OUT; i++) w_v[i] = '0;
        for (int n = 0; n < OUT; n++) b_v[n] = 16'(256 * n);
        mode = 2'b01;
        predict(); accept("bias"); finish_run("bias");
        for (int n = 0; n < OUT; n++)
            check($sformatf("bias const[%0d]", n), out_v[n], 256 * n);

        for (int t = 0; t < 6; t++) begin
            fill_rand((t % 2 == 0) ? 1024 : 128);
            predict();
            accept($sformatf("rand%0d", t));
            finish_run($sformatf("rand%0d", t));
        end

        fill_rand(512);
        predict();
        accept("ignore");
        for (int k = 0; k < IN; k++) in_v[k] = rnd16(512);
        mode = ~mode;
        repeat (19) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("ignore busy", busy, 1);
        check("ignore ready", ready, 0);
        finish_run("ignore");

        fill_rand(512);
        predict();
        start = 1'b1;
        @(posedge clock); #1;
        mark();
        finish_run("held");
        @(posedge clock); #1;
        mark();
        start = 1'b0;
        check("held ready pulse", ready, 0);
        check("held rerun busy", busy, 1);
        finish_run("held2");

        fill_rand(512);
        predict();
        accept("abort");
        repeat (29) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort ready", ready, 0);
        check("abort busy", busy, 0);
        check("abort sat", sat_count, 0);
        for (int n = 0; n < OUT; n++)
            check($sformatf("abort out[%0d]", n), out_v[n], 0);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        fill_rand(1024);
        predict();
        accept("fresh");
        finish_run("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
